// File: rtl/gerador_eco_cm_pkg.sv
// gerador_eco_cm_pkg: 3-digit BCD distance type and helpers
package gerador_eco_cm_pkg;
  typedef struct packed {
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd3_t;
  function automatic logic bcd_ok(input bcd3_t v);
    return (v.d2 <= 4'd9) && (v.d1 <= 4'd9) && (v.d0 <= 4'd9);
  endfunction
  function automatic bcd3_t bcd_dec(input bcd3_t v);
    bcd3_t r;
    r = v;
    if (v.d0 != 4'd0) r.d0 = v.d0 - 4'd1;
    else begin
      r.d0 = 4'd9;
      if (v.d1 != 4'd0) r.d1 = v.d1 - 4'd1;
      else begin
        r.d1 = 4'd9;
        r.d2 = v.d2 - 4'd1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/contador_m.sv
// contador_m: mod-M counter with synchronous clear and end-of-count flag
module contador_m #(
  parameter int M = 50,
  parameter int N = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  logic [N-1:0] q;
  assign fim = q == N'(M - 1);
  always_ff @(posedge clock) begin
    if (reset || zera) q <= '0;
    else if (conta) q <= fim ? '0 : q + N'(1);
  end
endmodule

// File: rtl/gerador_eco_cm_uc.sv
// gerador_eco_cm_uc: control FSM of the echo generator with registered outputs
module gerador_eco_cm_uc (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic       gatilho_ok,
  input  logic       fim_atraso,
  input  logic       tick,
  input  logic       um,
  input  logic       zero,
  input  logic       invalido,
  output logic       zera_trig,
  output logic       conta_trig,
  output logic       carrega,
  output logic       conta_atraso,
  output logic       conta_cm,
  output logic       eco,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    s_inicial = 4'd0,
    s_mede    = 4'd1,
    s_atraso  = 4'd2,
    s_eco     = 4'd3,
    s_final   = 4'd4,
    s_falha   = 4'd5
  } estado_t;
  estado_t estado, prox;
  logic eco_d, pronto_d, erro_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= s_inicial;
      eco    <= 1'b0;
      pronto <= 1'b0;
      erro   <= 1'b0;
    end else begin
      estado <= prox;
      eco    <= eco_d;
      pronto <= pronto_d;
      erro   <= erro_d;
    end
  end
  always_comb begin
    prox = estado;
    case (estado)
      s_inicial: if (trigger) prox = s_mede;
      s_mede:    if (!trigger) prox = gatilho_ok ? s_atraso : s_inicial;
      s_atraso:  if (fim_atraso) prox = invalido ? s_falha : zero ? s_final : s_eco;
      s_eco:     if (tick && um) prox = s_final;
      default:   prox = s_inicial;
    endcase
  end
  // eco looks ahead so it is high exactly while in s_eco; pronto/erro follow the state
  always_comb begin
    zera_trig    = estado == s_inicial;
    conta_trig   = estado == s_mede;
    carrega      = estado == s_mede && !trigger && gatilho_ok;
    conta_atraso = estado == s_atraso;
    conta_cm     = estado == s_eco;
    eco_d        = prox == s_eco;
    pronto_d     = estado == s_final;
    erro_d       = estado == s_falha;
    db_estado    = estado;
  end
endmodule

// File: rtl/gerador_eco_cm.sv
// gerador_eco_cm: ultrasonic-sensor echo emulator, echo width = distance (BCD cm) * R clocks
module gerador_eco_cm #(
  parameter int R      = 2941,
  parameter int N      = 12,
  parameter int T_TRIG = 500,
  parameter int D_ECO  = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [3:0] digito2,
  input  logic [3:0] digito1,
  input  logic [3:0] digito0,
  output logic       eco,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);
  import gerador_eco_cm_pkg::*;
  localparam int NT = $clog2(T_TRIG + 1);
  localparam int ND = D_ECO > 1 ? $clog2(D_ECO) : 1;
  logic [NT-1:0] cnt_trig;
  bcd3_t dig, cop;
  logic zera_trig, conta_trig, carrega, conta_atraso, conta_cm;
  logic fim_atraso, fim_cm, tick;
  assign tick = conta_cm & fim_cm;
  // the cycle that leaves s_inicial already counts as the first trigger-high cycle
  always_ff @(posedge clock) begin
    if (reset) cnt_trig <= '0;
    else if (zera_trig) cnt_trig <= NT'(trigger);
    else if (conta_trig && trigger && cnt_trig != NT'(T_TRIG)) cnt_trig <= cnt_trig + NT'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      dig <= '0;
      cop <= '0;
    end else if (carrega) begin
      dig <= {digito2, digito1, digito0};
      cop <= {digito2, digito1, digito0};
    end else if (tick) cop <= bcd_dec(cop);
  end
  contador_m #(.M(R), .N(N)) u_cm (
    .clock(clock), .reset(reset), .zera(!conta_cm), .conta(conta_cm), .fim(fim_cm)
  );
  contador_m #(.M(D_ECO), .N(ND)) u_atraso (
    .clock(clock), .reset(reset), .zera(!conta_atraso), .conta(conta_atraso), .fim(fim_atraso)
  );
  gerador_eco_cm_uc u_uc (
    .clock(clock),
    .reset(reset),
    .trigger(trigger),
    .gatilho_ok(cnt_trig == NT'(T_TRIG)),
    .fim_atraso(fim_atraso),
    .tick(tick),
    .um(cop == 12'h001),
    .zero(dig == 12'h000),
    .invalido(!bcd_ok(dig)),
    .zera_trig(zera_trig),
    .conta_trig(conta_trig),
    .carrega(carrega),
    .conta_atraso(conta_atraso),
    .conta_cm(conta_cm),
    .eco(eco),
    .pronto(pronto),
    .erro(erro),
    .db_estado(db_estado)
  );
endmodule

// File: tb/tb_gerador_eco_cm.sv
// tb_gerador_eco_cm: randomized self-checking bench against a request-level timing model
module tb_gerador_eco_cm;
  localparam int R = 4, T_TRIG = 5, D_ECO = 3;
  logic clock = 1'b0, reset = 1'b1, trigger = 1'b0;
  logic [3:0] digito2 = '0, digito1 = '0, digito0 = '0;
  logic eco, pronto, erro;
  logic [3:0] db_estado;
  int n_checks = 0, n_ok = 0;
  always #5 clock = ~clock;
  gerador_eco_cm #(.R(R), .N(2), .T_TRIG(T_TRIG), .D_ECO(D_ECO)) dut (
    .clock(clock), .reset(reset), .trigger(trigger),
    .digito2(digito2), .digito1(digito1), .digito0(digito0),
    .eco(eco), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );
  task automatic verifica(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  // modo 0: random digit noise during the request; 1: digits->999 plus a valid second trigger
  // during eco; 2: reset on the 100th eco cycle. Offsets j count from the edge that sees trigger=0.
  task automatic pedido(input string nome, input int len, input int d2, input int d1, input int d0, input int modo);
    int v, x_eco, x_w, x_pr, x_er, budget;
    int eco_first, eco_cnt, eco_rises, pr_first, pr_cnt, er_first, er_cnt;
    logic prev;
    v = 100 * d2 + 10 * d1 + d0;
    x_eco = -1; x_w = 0; x_pr = -1; x_er = -1;
    if (len >= T_TRIG) begin
      if (d2 > 9 || d1 > 9 || d0 > 9) x_er = D_ECO + 1;
      else if (v == 0) x_pr = D_ECO + 1;
      else begin
        x_eco = D_ECO;
        x_w = v * R;
        x_pr = D_ECO + v * R + 1;
      end
    end
    if (modo == 2) begin
      x_w = 100;
      x_pr = -1;
    end
    budget = D_ECO + x_w + 8;
    eco_first = -1; eco_cnt = 0; eco_rises = 0; pr_first = -1; pr_cnt = 0; er_first = -1; er_cnt = 0;
    prev = 1'b0;
    @(negedge clock);
    digito2 = 4'(d2); digito1 = 4'(d1); digito0 = 4'(d0);
    trigger = 1'b1;
    repeat (len) @(negedge clock);
    trigger = 1'b0;
    for (int j = 0; j < budget; j++) begin
      @(negedge clock);
      if (eco) begin
        if (eco_first < 0) eco_first = j;
        eco_cnt++;
        if (!prev) eco_rises++;
      end
      prev = eco;
      if (pronto) begin
        if (pr_first < 0) pr_first = j;
        pr_cnt++;
      end
      if (erro) begin
        if (er_first < 0) er_first = j;
        er_cnt++;
      end
      if (reset) reset = 1'b0;
      if (modo == 2 && eco && eco_cnt == 100) reset = 1'b1;
      if (modo == 1) begin
        if (j == 5) begin
          digito2 = 4'd9; digito1 = 4'd9; digito0 = 4'd9;
          trigger = 1'b1;
        end
        if (j == 11) trigger = 1'b0;
      end else begin
        digito2 = 4'($urandom_range(0, 15));
        digito1 = 4'($urandom_range(0, 15));
        digito0 = 4'($urandom_range(0, 15));
      end
    end
    trigger = 1'b0;
    verifica({nome, " eco_start"}, eco_first, x_eco);
    verifica({nome, " eco_width"}, eco_cnt, x_w);
    verifica({nome, " eco_pulses"}, eco_rises, x_w > 0 ? 1 : 0);
    verifica({nome, " pronto_at"}, pr_first, x_pr);
    verifica({nome, " pronto_count"}, pr_cnt, x_pr >= 0 ? 1 : 0);
    verifica({nome, " erro_at"}, er_first, x_er);
    verifica({nome, " erro_count"}, er_cnt, x_er >= 0 ? 1 : 0);
    verifica({nome, " end_state"}, int'(db_estado), 0);
  endtask
  initial begin
    trigger = 1'b1;
    repeat (3) @(negedge clock);
    verifica("reset eco", int'(eco), 0);
    verifica("reset pronto", int'(pronto), 0);
    verifica("reset erro", int'(erro), 0);
    verifica("reset state_with_trigger", int'(db_estado), 0);
    trigger = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    pedido("d012", 5, 0, 1, 2, 0);
    pedido("short", 4, 0, 1, 2, 0);
    pedido("d000", 5, 0, 0, 0, 0);
    pedido("d0A3", 5, 0, 10, 3, 0);
    pedido("retrig", 5, 0, 0, 5, 1);
    pedido("rst999", 5, 9, 9, 9, 2);
    pedido("after_rst", 6, 0, 0, 7, 0);
    for (int k = 0; k < 14; k++)
      pedido($sformatf("rnd%0d", k), $urandom_range(3, 8), $urandom_range(0, 1),
             $urandom_range(0, 11), $urandom_range(0, 11), 0);
    $display("%0d/%0d checks passed", n_ok, n_checks);
    $finish;
  end
endmodule

// File: doc/gerador_eco_cm.md
GERADOR_ECO_CM -- requirements
Module: gerador_eco_cm

Interface
REQ-001 Parameter R, default 2941, clocks per cm of echo width (50 MHz).
REQ-002 Parameter N, default 12, ceil(log2(R)).
REQ-003 Parameter T_TRIG, default 500, minimum valid trigger width in clocks.
REQ-004 Parameter D_ECO, default 25000, clocks from trigger fall to echo rise.
REQ-005 Port list SHALL be:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- trigger  in  1  measurement request, synchronous to clock.
- digito2  in  4  distance BCD hundreds.
- digito1  in  4  distance BCD tens.
- digito0  in  4  distance BCD units.
- eco  out  1  echo pulse, width = distance*R clocks.
- pronto  out  1  one-cycle pulse at end of each accepted request.
- erro  out  1  one-cycle pulse when the latched distance is not valid BCD.
- db_estado  out  4  current FSM state code.

Function
REQ-006 FSM states and codes: inicial=0, mede_trigger=1, atraso=2, eco_alto=3, final=4, falha=5.
REQ-007 inicial: trigger=1 goes to mede_trigger and clears the trigger-width counter.
REQ-008 mede_trigger: counts every cycle trigger=1, saturating at T_TRIG.
REQ-009 mede_trigger, trigger=0 with count<T_TRIG: return to inicial with no output activity (short trigger ignored).
REQ-010 mede_trigger, trigger=0 with count>=T_TRIG: latch digito2..0 on that edge and go to atraso.
REQ-011 Latched digits are frozen until the next latch; input changes have no effect during the request.
REQ-012 atraso: lasts exactly D_ECO cycles.
REQ-013 After atraso, any latched digit >9 goes to falha; otherwise eco_alto, or final directly when the latched value is 000.
REQ-014 eco_alto: eco=1 for exactly (100*d2+10*d1+d0)*R cycles.
REQ-015 Echo width SHALL come from a per-cm tick (mod-R counter) decrementing a 3-digit BCD copy of the latched value; leave eco_alto on the tick that takes the copy from 001 to 000.
REQ-016 final: pronto=1 for one cycle, then inicial.
REQ-017 falha: erro=1 for one cycle, eco stays 0, pronto stays 0, then inicial.
REQ-018 eco, pronto and erro SHALL be registered; eco is high exactly while in eco_alto.
REQ-019 trigger activity in atraso, eco_alto, final or falha is ignored.
REQ-020 A new trigger is accepted only from inicial, no earlier than the cycle after final or falha.
REQ-021 Distance range is 000..999 cm; maximum echo is 999*R cycles. Counters SHALL not overflow for any N >= ceil(log2(R)).

Reset
REQ-022 reset=1 at a clock edge SHALL force inicial, eco=0, pronto=0, erro=0, db_estado=0, and clear all counters and latched digits to 0.
REQ-023 reset asserted mid-operation, including during eco_alto, SHALL drop eco on that edge with no pronto or erro pulse.
REQ-024 reset has priority over trigger in the same cycle.

Structure
REQ-025 No shared package is required. State codes are local constants; R, T_TRIG and D_ECO stay parameters overridable from the top level.
REQ-026 The FSM SHALL be a separate sub-module gerador_eco_cm_uc.
REQ-027 The datapath SHALL reuse the existing mod-M counter, with M=R, for the per-cm tick, plus a 3-digit BCD down-counter.

Verification
REQ-028 The bench SHALL use R=4, T_TRIG=5, D_ECO=3.
REQ-029 Trigger high 5 cycles with digits 0,1,2 -> eco rises 3 cycles after trigger falls, stays high exactly 48 cycles, then pronto is 1 for one cycle.
REQ-030 Trigger high 4 cycles -> eco, pronto and erro stay 0; state returns to 0.
REQ-031 Digits 0,0,0 with a valid trigger -> no eco; pronto pulses 4 cycles after trigger falls.
REQ-032 Digits 0,A,3 with a valid trigger -> eco stays 0; erro pulses once; pronto stays 0.
REQ-033 Distance 0,0,5, then digits changed to 9,9,9 and a second trigger pulse applied during eco -> eco width stays 20 cycles; the second trigger is ignored.
REQ-034 Distance 9,9,9 with reset asserted at the 100th eco cycle -> eco is 0 on the next edge; no pronto; a following valid trigger works normally.
